booth_r4_multiplier: RTL and testbench

//  Sequential radix-4 Booth multiplier; successor to the fixed 5-bit radix-2 multiplier.
//  - Width is parametrised.
//  - Signed or unsigned mode is selected per operation.
//  - Two partial-product bits are retired per cycle.
//  - Operands enter and the full 2W-bit product leaves over valid/ready handshakes,
//    so the block sits directly between a producer FIFO and a result consumer.

---
 rtl/booth_pkg.sv | 23 ++
 rtl/booth_r4_multiplier_if.sv | 36 +++
 rtl/booth_r4_enc.sv | 24 ++
 rtl/booth_r4_multiplier.sv | 117 +++++++++++
 tb/tb_booth_r4_multiplier.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier.
// State encoding, digit select codes and iteration count.
package booth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        DIG_ZERO,
        DIG_P1,
        DIG_P2,
        DIG_N1,
        DIG_N2
    } digit_t;

    function automatic int iter_of(input int w);
        return w / 2 + 1;
    endfunction

endpackage

// File: rtl/booth_r4_multiplier_if.sv
// Operand and product handshake bundle.
// The multiplier uses the slave side; producers/consumers use master.
interface booth_r4_multiplier_if #(
    parameter int W = 8
);
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [W-1:0]   in_m;
    logic [W-1:0]   in_q;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] out_product;

    modport master (
        output in_valid,
        output in_signed,
        output in_m,
        output in_q,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_product
    );

    modport slave (
        input  in_valid,
        input  in_signed,
        input  in_m,
        input  in_q,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_product
    );
endinterface

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth recoder.
// Maps {Q[1],Q[0],Q[-1]} to a digit select code.
module booth_r4_enc
    import booth_pkg::*;
(
    input  logic [2:0] trip,
    output digit_t     dig
);

    always_comb begin
        dig = DIG_ZERO;
        unique case (trip)
            3'b000: dig = DIG_ZERO;
            3'b001: dig = DIG_P1;
            3'b010: dig = DIG_P1;
            3'b011: dig = DIG_P2;
            3'b100: dig = DIG_N2;
            3'b101: dig = DIG_N1;
            3'b110: dig = DIG_N1;
            3'b111: dig = DIG_ZERO;
        endcase
    end

endmodule

// File: rtl/booth_r4_multiplier.sv
// Sequential radix-4 Booth multiplier, signed/unsigned per operation.
// Retires one Booth digit per cycle; ITER = W/2+1 digits per product.
module booth_r4_multiplier
    import booth_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  n_rst,
    booth_r4_multiplier_if.slave  bus,
    output logic                  busy
);

    localparam int ITER = iter_of(W);
    localparam int XW   = W + 2;
    localparam int SW   = W + 3;
    localparam int PW   = 2 * W + 4;
    localparam int CW   = $clog2(ITER + 1);

    state_t         state;
    logic [XW-1:0]  m_x;
    logic [PW-1:0]  prod;
    logic           q_m1;
    logic [CW-1:0]  cnt;
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] out_product;

    digit_t         dig;
    logic [SW-1:0]  m_s;
    logic [SW-1:0]  mult;
    logic [SW-1:0]  sum;
    logic [PW-1:0]  next_p;
    logic [XW-1:0]  m_ext;
    logic [XW-1:0]  q_ext;

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.out_product = out_product;

    booth_r4_enc u_enc (
        .trip ({prod[1:0], q_m1}),
        .dig  (dig)
    );

    always_comb begin
        m_ext = bus.in_signed ? {{2{bus.in_m[W-1]}}, bus.in_m}
                              : {2'b00, bus.in_m};
        q_ext = bus.in_signed ? {{2{bus.in_q[W-1]}}, bus.in_q}
                              : {2'b00, bus.in_q};
    end

    // W+3 bits keep +-2M exact; the shift re-extends the full sum.
    always_comb begin
        m_s  = {m_x[XW-1], m_x};
        mult = '0;
        unique case (dig)
            DIG_ZERO: mult = '0;
            DIG_P1:   mult = m_s;
            DIG_P2:   mult = m_s << 1;
            DIG_N1:   mult = -m_s;
            DIG_N2:   mult = -(m_s << 1);
            default:  mult = '0;
        endcase
        sum    = {prod[PW-1], prod[PW-1:XW]} + mult;
        next_p = {sum[SW-1], sum, prod[XW-1:2]};
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= ST_IDLE;
            m_x         <= '0;
            prod        <= '0;
            q_m1        <= 1'b0;
            cnt         <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_product <= '0;
            busy        <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    in_ready <= 1'b1;
                    if (bus.in_valid && in_ready) begin
                        m_x      <= m_ext;
                        prod     <= {{XW{1'b0}}, q_ext};
                        q_m1     <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    prod <= next_p;
                    q_m1 <= prod[1];
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(ITER - 1)) begin
                        out_product <= next_p[2*W-1:0];
                        out_valid   <= 1'b1;
                        state       <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_r4_multiplier.sv
// Directed and randomised checks for booth_r4_multiplier at W=8.
// Expected products come from constants or a behavioural multiply.
module tb_booth_r4_multiplier;

    logic clk;
    logic n_rst;
    logic busy;
    int   n_chk;
    int   n_pass;

    booth_r4_multiplier_if #(.W(8)) bus ();

    booth_r4_multiplier #(.W(8)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] ref_mul(input logic s,
                                            input logic [7:0] m,
                                            input logic [7:0] q);
        logic [15:0] r;
        if (s) r = $signed(m) * $signed(q);
        else   r = m * q;
        return r;
    endfunction

    task automatic wait_ready();
        int n;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 0, 1);
    endtask

    // Issue one op; check latency and product; drain with optional stall.
    task automatic do_op(input string tag, input logic s,
                         input logic [7:0] m, input logic [7:0] q,
                         input logic [15:0] exp, input int stall,
                         input bit chk_lat);
        int n;
        wait_ready();
        bus.in_valid  = 1'b1;
        bus.in_signed = s;
        bus.in_m      = m;
        bus.in_q      = q;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.in_signed = ~s;
        bus.in_m      = ~m;
        bus.in_q      = 8'h5A;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (chk_lat) chk({tag, "_lat"}, n, 5);
        chk({tag, "_prod"}, bus.out_product, exp);
        repeat (stall) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        if (chk_lat) chk({tag, "_drop"}, bus.out_valid, 0);
    endtask

    initial begin
        logic [7:0]  rm;
        logic [7:0]  rq;
        logic        rs;
        logic [15:0] hold;
        n_chk  = 0;
        n_pass = 0;
        n_rst  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_signed = 1'b0;
        bus.in_m      = '0;
        bus.in_q      = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_product",   bus.out_product, 0);
        chk("rst_busy",      busy, 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready_up", bus.in_ready, 1);

        do_op("u_ff_ff", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 0, 1);
        do_op("s_80_80", 1'b1, 8'h80, 8'h80, 16'h4000, 0, 1);
        do_op("s_ff_03", 1'b1, 8'hFF, 8'h03, 16'hFFFD, 0, 1);
        do_op("s_ff_ff", 1'b1, 8'hFF, 8'hFF, 16'h0001, 0, 1);
        do_op("u_ff_ff2", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 0, 1);
        do_op("s_7f_80", 1'b1, 8'h7F, 8'h80, 16'hC080, 0, 1);
        do_op("u_80_80", 1'b0, 8'h80, 8'h80, 16'h4000, 0, 1);
        do_op("u_00_ff", 1'b0, 8'h00, 8'hFF, 16'h0000, 0, 1);

        // Backpressure: stalled result stays put, new operands refused.
        wait_ready();
        bus.in_valid = 1'b1;
        bus.in_signed = 1'b0;
        bus.in_m = 8'd3;
        bus.in_q = 8'd5;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_valid", bus.out_valid, 1);
        chk("bp_prod", bus.out_product, 16'h000F);
        hold = bus.out_product;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = i[0];
            bus.in_m = 8'hAA;
            bus.in_q = 8'h55;
            @(posedge clk); #1;
            chk("bp_hold_valid", bus.out_valid, 1);
            chk("bp_hold_prod", bus.out_product, 32'(hold));
            chk("bp_hold_ready", bus.in_ready, 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        chk("bp_rel_valid", bus.out_valid, 0);
        chk("bp_rel_ready", bus.in_ready, 1);
        chk("bp_rel_busy", busy, 0);

        // Abort mid-calculation.
        bus.in_valid = 1'b1;
        bus.in_signed = 1'b0;
        bus.in_m = 8'd200;
        bus.in_q = 8'd200;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        chk("abort_valid", bus.out_valid, 0);
        chk("abort_prod", bus.out_product, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ready", bus.in_ready, 0);
        @(negedge clk);
        n_rst = 1'b1;
        do_op("u_7_6", 1'b0, 8'd7, 8'd6, 16'h002A, 0, 1);

        for (int i = 0; i < 300; i++) begin
            rm = 8'($urandom);
            rq = 8'($urandom);
            rs = 1'($urandom);
            do_op("rand", rs, rm, rq, ref_mul(rs, rm, rq),
                  int'($urandom_range(0, 3)), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
